// File: rtl/std_binary_encoder_serial.sv
// Serializing binary encoder: accepts a unary (multi-hot) vector and emits
// the binary index of every set bit, lowest first, one index per beat.
module std_binary_encoder_serial #(
  parameter int unsigned BIN_WIDTH = 3,
  localparam int unsigned UNARY_WIDTH = 1 << BIN_WIDTH
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [UNARY_WIDTH-1:0] i_unary,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [BIN_WIDTH-1:0]   o_bin,
  output logic                   o_last,
  output logic                   o_none
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic [UNARY_WIDTH-1:0] r_pend;
  logic [UNARY_WIDTH-1:0] w_pend_nxt;
  logic                   r_zero_vec;
  logic                   w_zero_vec_nxt;

  logic [BIN_WIDTH-1:0]   w_low_idx;
  logic [UNARY_WIDTH-1:0] w_pend_clr;
  logic                   w_last;

  // Lowest set bit index of the pending vector (0 when nothing is pending).
  always_comb begin
    w_low_idx = '0;
    for (int i = UNARY_WIDTH - 1; i >= 0; i--) begin
      if (r_pend[i]) w_low_idx = BIN_WIDTH'(i);
    end
  end

  // Clearing the lowest set bit; at most one bit pending means this beat is final.
  assign w_pend_clr = r_pend & (r_pend - UNARY_WIDTH'(1));
  assign w_last     = (w_pend_clr == '0);

  // State register with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= StIdle;
      r_pend     <= '0;
      r_zero_vec <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pend     <= w_pend_nxt;
      r_zero_vec <= w_zero_vec_nxt;
    end
  end

  // Next-state and outputs; beat outputs depend only on registered state.
  always_comb begin
    w_state_nxt    = r_state;
    w_pend_nxt     = r_pend;
    w_zero_vec_nxt = r_zero_vec;
    o_ready        = 1'b0;
    o_valid        = 1'b0;
    o_bin          = '0;
    o_last         = 1'b0;
    o_none         = 1'b0;
    unique case (r_state)
      StIdle: begin
        o_ready = 1'b1;
        if (i_valid) begin
          w_state_nxt    = StBusy;
          w_pend_nxt     = i_unary;
          w_zero_vec_nxt = (i_unary == '0);
        end
      end
      StBusy: begin
        o_valid = 1'b1;
        o_bin   = w_low_idx;
        o_last  = w_last;
        o_none  = r_zero_vec;
        // Ready only when the final beat leaves, so the next vector follows without a bubble.
        o_ready = i_ready & w_last;
        if (i_ready) begin
          if (!w_last) begin
            w_pend_nxt = w_pend_clr;
          end else if (i_valid) begin
            w_pend_nxt     = i_unary;
            w_zero_vec_nxt = (i_unary == '0);
          end else begin
            w_state_nxt    = StIdle;
            w_pend_nxt     = '0;
            w_zero_vec_nxt = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

endmodule
